// File: rtl/tlb_walk_arb.sv
// tlb_walk_arb: shared Sv39 page-table walker with round-robin arbitration between the iside and dside tlb misses.
package tlb_walk_arb_pkg;
    typedef struct packed {
        logic [63:0] paddr;
        logic        dirty;
        logic        readable;
        logic        writable;
        logic        executable;
        logic        user;
    } page_walk_rsp_t;
endpackage

module tlb_walk_arb
    import tlb_walk_arb_pkg::*;
#(
    parameter int PA_W = 56
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [43:0]    i_satp_ppn,
    input  logic           i_clear,
    input  logic           i_itlb_miss,
    input  logic [63:0]    i_itlb_va,
    input  logic           i_dtlb_miss,
    input  logic [63:0]    i_dtlb_va,
    output logic           o_mem_req,
    output logic [63:0]    o_mem_addr,
    input  logic           i_mem_rsp_valid,
    input  logic [63:0]    i_mem_rsp_data,
    output logic           o_itlb_replace,
    output logic           o_dtlb_replace,
    output logic [63:0]    o_replace_va,
    output page_walk_rsp_t o_page_walk_rsp,
    output logic           o_walk_fault,
    output logic           o_walk_fault_iside,
    output logic           o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [63:0] PA_MASK = (64'd1 << PA_W) - 64'd1;

    state_t         r_state, w_next;
    logic [1:0]     r_level;
    logic [43:0]    r_ppn;
    logic [63:0]    r_va;
    logic           r_iside, r_last_i, r_abort, r_fault;
    page_walk_rsp_t r_rsp;

    logic           w_any, w_grant_i, w_v, w_r, w_w, w_x, w_leaf, w_misal, w_fault, w_done, w_stop;
    logic [8:0]     w_vpn;
    logic [43:0]    w_pte_ppn;
    logic [55:0]    w_paddr_raw;
    logic [63:0]    w_paddr;
    logic           w_unused;

    // r_last_i resets high so the first simultaneous miss goes to the dside
    assign w_any       = i_itlb_miss | i_dtlb_miss;
    assign w_grant_i   = i_itlb_miss && (!i_dtlb_miss || !r_last_i);
    assign w_vpn       = r_level == 2'd2 ? r_va[38:30] : r_level == 2'd1 ? r_va[29:21] : r_va[20:12];
    assign w_pte_ppn   = i_mem_rsp_data[53:10];
    assign w_v         = i_mem_rsp_data[0];
    assign w_r         = i_mem_rsp_data[1];
    assign w_w         = i_mem_rsp_data[2];
    assign w_x         = i_mem_rsp_data[3];
    assign w_leaf      = w_r | w_x;
    assign w_misal     = w_leaf && (r_level == 2'd2 ? |w_pte_ppn[17:0] : r_level == 2'd1 ? |w_pte_ppn[8:0] : 1'b0);
    assign w_fault     = !w_v || (w_w && !w_r) || w_misal || (!w_leaf && r_level == 2'd0);
    assign w_paddr_raw = r_level == 2'd2 ? {w_pte_ppn[43:18], r_va[29:0]} :
                         r_level == 2'd1 ? {w_pte_ppn[43:9], r_va[20:0]} : {w_pte_ppn, r_va[11:0]};
    assign w_paddr     = {8'b0, w_paddr_raw} & PA_MASK;
    assign w_stop      = r_abort | i_clear;
    assign w_done      = r_state == DONE && !i_clear;
    assign w_unused    = ^{i_mem_rsp_data[63:54], i_mem_rsp_data[9:8], i_mem_rsp_data[6:5]};

    assign o_mem_req          = r_state == ISSUE;
    assign o_mem_addr         = {8'b0, r_ppn, w_vpn, 3'b0};
    assign o_itlb_replace     = w_done && !r_fault && r_iside;
    assign o_dtlb_replace     = w_done && !r_fault && !r_iside;
    assign o_walk_fault       = w_done && r_fault;
    assign o_walk_fault_iside = r_iside;
    assign o_replace_va       = r_va;
    assign o_page_walk_rsp    = r_rsp;
    assign o_busy             = r_state != IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = w_any ? ISSUE : IDLE;
            ISSUE: w_next = WAIT;
            WAIT:  if (i_mem_rsp_valid) w_next = w_stop ? IDLE : (w_fault || w_leaf) ? DONE : ISSUE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_level  <= 2'd0;
            r_ppn    <= '0;
            r_va     <= '0;
            r_iside  <= 1'b0;
            r_last_i <= 1'b1;
            r_abort  <= 1'b0;
            r_fault  <= 1'b0;
            r_rsp    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_iside  <= w_grant_i;
                r_last_i <= w_grant_i;
                r_va     <= w_grant_i ? i_itlb_va : i_dtlb_va;
                r_ppn    <= i_satp_ppn;
                r_level  <= 2'd2;
                r_abort  <= 1'b0;
            end
            if ((r_state == ISSUE || r_state == WAIT) && i_clear)
                r_abort <= 1'b1;
            if (r_state == WAIT && i_mem_rsp_valid && !w_stop) begin
                r_fault <= w_fault;
                if (!w_fault && !w_leaf) begin
                    r_ppn   <= w_pte_ppn;
                    r_level <= r_level - 2'd1;
                end
                if (!w_fault && w_leaf) begin
                    r_rsp.paddr      <= w_paddr;
                    r_rsp.dirty      <= i_mem_rsp_data[7];
                    r_rsp.readable   <= w_r;
                    r_rsp.writable   <= w_w;
                    r_rsp.executable <= w_x;
                    r_rsp.user       <= i_mem_rsp_data[4];
                end
            end
        end
    end
endmodule

// File: tb/tb_tlb_walk_arb.sv
// tb_tlb_walk_arb: directed vectors over a small fixed page table, plus arbitration, clear and reset sequences.
module tb_tlb_walk_arb;
    import tlb_walk_arb_pkg::*;

    logic           clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic [43:0]    satp_ppn = 44'h100;
    logic           itlb_miss = 1'b0, dtlb_miss = 1'b0;
    logic [63:0]    itlb_va = '0, dtlb_va = '0;
    logic           mem_req, mem_rsp_valid = 1'b0;
    logic [63:0]    mem_addr, mem_rsp_data = '0, replace_va;
    logic           itlb_replace, dtlb_replace, walk_fault, walk_fault_iside, busy;
    page_walk_rsp_t rsp;

    tlb_walk_arb dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_satp_ppn(satp_ppn), .i_clear(clear),
        .i_itlb_miss(itlb_miss), .i_itlb_va(itlb_va), .i_dtlb_miss(dtlb_miss), .i_dtlb_va(dtlb_va),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rsp_data(mem_rsp_data),
        .o_itlb_replace(itlb_replace), .o_dtlb_replace(dtlb_replace), .o_replace_va(replace_va),
        .o_page_walk_rsp(rsp), .o_walk_fault(walk_fault), .o_walk_fault_iside(walk_fault_iside), .o_busy(busy)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [logic [63:0]];
    int n_err = 0, n_chk = 0, n_req = 0, n_pulse = 0, lat = 0, cnt = 0;
    bit pend = 0;
    logic [63:0] pdata;

    function automatic logic [63:0] pte(input logic [43:0] ppn, input logic [7:0] fl);
        return {10'b0, ppn, 2'b0, fl};
    endfunction

    function automatic logic [63:0] pa(input logic [43:0] tbl, input int idx);
        return {8'b0, tbl, 12'b0} + 64'(idx * 8);
    endfunction

    // single-beat memory: answers each request lat+1 cycles later, never alongside a request
    always begin
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        if (!rst_n) pend = 0;
        else begin
            if (pend) begin
                if (cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data = pdata;
                    pend = 0;
                end else cnt--;
            end
            if (mem_req) begin
                pend = 1;
                cnt = lat;
                pdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
                n_req++;
            end
            if (itlb_replace || dtlb_replace || walk_fault) n_pulse++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_pulse(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(itlb_replace || dtlb_replace || walk_fault) && c < 60);
    endtask

    typedef struct {
        bit          is_i;
        logic [63:0] va;
        bit          flt;
        logic [63:0] paddr;
        logic [4:0]  fl;
        int          nreq;
    } vec_t;

    task automatic run(input vec_t v, input string nm);
        int c, n0;
        n0 = n_req;
        @(negedge clk);
        itlb_miss = v.is_i;
        itlb_va = v.va;
        dtlb_miss = !v.is_i;
        dtlb_va = v.va;
        wait_pulse(c);
        chk({nm, "_pulse"}, {61'b0, itlb_replace, dtlb_replace, walk_fault},
            v.flt ? 64'b001 : v.is_i ? 64'b100 : 64'b010);
        if (v.flt) chk({nm, "_fiside"}, {63'b0, walk_fault_iside}, {63'b0, v.is_i});
        chk({nm, "_va"}, replace_va, v.va);
        chk({nm, "_nreq"}, 64'(n_req - n0), 64'(v.nreq));
        chk({nm, "_cycles"}, 64'(c), 64'(1 + 2 * v.nreq));
        if (!v.flt) begin
            chk({nm, "_paddr"}, rsp.paddr, v.paddr);
            chk({nm, "_flags"}, {59'b0, rsp.dirty, rsp.readable, rsp.writable, rsp.executable, rsp.user}, {59'b0, v.fl});
        end
        itlb_miss = 1'b0;
        dtlb_miss = 1'b0;
    endtask

    task automatic rr_round(input string nm);
        int c;
        @(negedge clk);
        itlb_miss = 1'b1;
        itlb_va = 64'hD234_5678;
        dtlb_miss = 1'b1;
        dtlb_va = 64'h4000_5123;
        wait_pulse(c);
        chk({nm, "_first"}, {62'b0, itlb_replace, dtlb_replace}, 64'b01);
        chk({nm, "_first_va"}, replace_va, 64'h4000_5123);
        chk({nm, "_first_pa"}, rsp.paddr, 64'h8000_1123);
        dtlb_miss = 1'b0;
        wait_pulse(c);
        chk({nm, "_second"}, {62'b0, itlb_replace, dtlb_replace}, 64'b10);
        chk({nm, "_second_pa"}, rsp.paddr, 64'h5234_5678);
        itlb_miss = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int c, n0, p0;
        mem[pa(44'h100, 1)] = pte(44'h101, 8'h01);
        mem[pa(44'h100, 2)] = pte(44'h103, 8'h01);
        mem[pa(44'h100, 3)] = pte(44'h40000, 8'h0B);
        mem[pa(44'h100, 5)] = pte(44'h104, 8'h01);
        mem[pa(44'h100, 6)] = pte(44'h200, 8'h05);
        mem[pa(44'h101, 0)] = pte(44'h102, 8'h01);
        mem[pa(44'h102, 5)] = pte(44'h80001, 8'h97);
        mem[pa(44'h102, 6)] = pte(44'h105, 8'h01);
        mem[pa(44'h103, 0)] = pte(44'h80200, 8'hCF);
        mem[pa(44'h103, 1)] = pte(44'h80201, 8'h0F);
        vecs[0] = '{0, 64'h4000_5123,   0, 64'h8000_1123, 5'b11101, 3};
        vecs[1] = '{1, 64'h8001_2345,   0, 64'h8021_2345, 5'b11110, 2};
        vecs[2] = '{0, 64'h8020_0555,   1, 64'h0,         5'b00000, 2};
        vecs[3] = '{1, 64'hD234_5678,   0, 64'h5234_5678, 5'b01010, 1};
        vecs[4] = '{0, 64'h1_0000_0000, 1, 64'h0,         5'b00000, 1};
        vecs[5] = '{1, 64'h1_4000_0000, 1, 64'h0,         5'b00000, 2};
        vecs[6] = '{0, 64'h1_8000_0000, 1, 64'h0,         5'b00000, 1};
        vecs[7] = '{1, 64'h4000_6000,   1, 64'h0,         5'b00000, 3};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {59'b0, busy, mem_req, itlb_replace, dtlb_replace, walk_fault}, 64'h0);
        chk("reset_rsp", rsp.paddr, 64'h0);
        chk("reset_va", replace_va, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run(vecs[i], $sformatf("vec%0d", i));

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rr_round("rr1");
        rr_round("rr2");

        lat = 3;
        n0 = n_req;
        p0 = n_pulse;
        @(negedge clk);
        dtlb_miss = 1'b1;
        dtlb_va = 64'h4000_5123;
        c = 0;
        do begin @(negedge clk); c++; end while (!mem_req && c < 20);
        @(negedge clk);
        clear = 1'b1;
        dtlb_miss = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end while (!mem_rsp_valid && c < 20);
        chk("clear_rsp_seen", {63'b0, mem_rsp_valid}, 64'h1);
        chk("clear_busy_at_rsp", {63'b0, busy}, 64'h1);
        @(negedge clk);
        chk("clear_busy_after", {63'b0, busy}, 64'h0);
        chk("clear_nreq", 64'(n_req - n0), 64'h1);
        chk("clear_no_pulse", 64'(n_pulse - p0), 64'h0);
        lat = 0;
        run(vecs[0], "after_clear");

        lat = 3;
        @(negedge clk);
        dtlb_miss = 1'b1;
        dtlb_va = 64'h8001_2345;
        c = 0;
        do begin @(negedge clk); c++; end while (!mem_req && c < 20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        dtlb_miss = 1'b0;
        #1;
        chk("async_rst_ctrl", {59'b0, busy, mem_req, itlb_replace, dtlb_replace, walk_fault}, 64'h0);
        chk("async_rst_rsp", rsp.paddr, 64'h0);
        chk("async_rst_va", replace_va, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        run(vecs[0], "after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
